// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// One quotient bit is resolved per clock by shift-and-subtract through a
// ripple-carry subtractor one bit wider than the operands. The quotient
// and remainder are returned packed as {remainder, quotient}, and the
// caller talks to the divider through a start/done handshake.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     opA,
  input  logic [WIDTH-1:0]     opB,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero
);

  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Architectural state
  logic [1:0]          state_q,  state_d;
  logic [WIDTH-1:0]    q_q,      q_d;       // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]    d_q,      d_d;       // captured divisor
  logic [WIDTH-1:0]    r_q,      r_d;       // partial remainder
  logic [CNT_W-1:0]    cnt_q,    cnt_d;     // iteration counter
  logic [2*WIDTH-1:0]  result_q, result_d;
  logic                dbz_q,    dbz_d;

  // Subtractor datapath: T = S + ~{0,D} + 1, built as an explicit ripple chain
  logic [WIDTH:0]      sub_a;     // S = {R, Q msb}
  logic [WIDTH:0]      sub_b;     // ~{0, D}
  logic [WIDTH:0]      sub_sum;   // T
  logic [WIDTH:0]      sub_c;     // carry into each bit; sub_c[0] is the +1

  assign sub_a    = {r_q, q_q[WIDTH-1]};
  assign sub_b    = ~{1'b0, d_q};
  assign sub_c[0] = 1'b1;

  // One full-adder cell per bit; the carry out of the top bit is not needed
  // because T[WIDTH] alone tells whether the trial subtraction went negative.
  for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_sub
    assign sub_sum[gi] = sub_a[gi] ^ sub_b[gi] ^ sub_c[gi];
    if (gi < WIDTH) begin : g_carry
      assign sub_c[gi+1] = (sub_a[gi] & sub_b[gi]) |
                           (sub_a[gi] & sub_c[gi]) |
                           (sub_b[gi] & sub_c[gi]);
    end
  end

  // Trial subtraction succeeded when the result is non-negative
  logic sub_ok;
  assign sub_ok = ~sub_sum[WIDTH];

  // Next-state and datapath update for the IDLE / RUN / DONE sequence
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    d_d      = d_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (opB != '0) begin
            q_d     = opA;
            d_d     = opB;
            r_d     = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = ST_RUN;
          end else begin
            // Division by zero finishes immediately: remainder = dividend,
            // quotient = all ones, and no RUN cycles are spent.
            result_d = {opA, {WIDTH{1'b1}}};
            dbz_d    = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        if (sub_ok) begin
          r_d = sub_sum[WIDTH-1:0];
        end else begin
          r_d = sub_a[WIDTH-1:0];
        end
        q_d   = {q_q[WIDTH-2:0], sub_ok};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          result_d = {r_d, q_d};
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset wins over any request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      d_q      <= d_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  // Status outputs are straight decodes of the state register, so busy and
  // done can never be high together.
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule
